// File: rtl/garage_pkg.sv
// garage_pkg: shared gate state type and timer sizing helper
package garage_pkg;
  typedef enum logic [1:0] {IDLE, OPEN, CLOSING} gate_state_t;
  // Width able to hold 0 .. max(a, b)-1, never less than one bit.
  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/garage_gate_fsm.sv
// garage_gate_fsm: one gate's open/timeout/close sequencer
//  clk, rst        clock, synchronous active-high reset
//  request, permit open from IDLE when both are high
//  pass            car cleared the sensor (honoured only while OPEN)
//  door            registered actuator, high only in OPEN
//  pass_accepted   pass seen while OPEN (single-cycle)
//  timeout         OPEN expired without a pass (single-cycle)
module garage_gate_fsm
  import garage_pkg::*;
#(
  parameter int unsigned OPEN_TIMEOUT = 16,
  parameter int unsigned CLOSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic request,
  input  logic permit,
  input  logic pass,
  output logic door,
  output logic pass_accepted,
  output logic timeout
);
  localparam int TW = timer_w(OPEN_TIMEOUT, CLOSE_CYCLES);
  gate_state_t state, state_nx;
  logic [TW-1:0] timer;
  logic open_end, close_end;
  always_comb begin
    open_end = timer == TW'(OPEN_TIMEOUT - 1);
    close_end = timer == TW'(CLOSE_CYCLES - 1);
    pass_accepted = state == OPEN && pass;
    timeout = state == OPEN && !pass && open_end;
    state_nx = state;
    case (state)
      IDLE:    state_nx = (request && permit) ? OPEN : IDLE;
      OPEN:    state_nx = (pass || open_end) ? CLOSING : OPEN;
      CLOSING: state_nx = close_end ? IDLE : CLOSING;
      default: state_nx = IDLE;
    endcase
  end
  // The timer restarts on every state change so it measures time spent in the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= (state_nx != state || state == IDLE) ? '0 : timer + 1'b1;
    end
  end
  assign door = state == OPEN;
endmodule

// File: rtl/garage_gate_controller.sv
// garage_gate_controller: entry/exit gates with reserved-capacity occupancy tracking
//  Clk, Reset                          clock, synchronous active-high reset
//  Car_entry_request, Car_exit_request level requests from waiting cars
//  Entry_passed, Exit_passed           single-cycle sensor pulses
//  Open_entry_door, Open_exit_door     registered door actuators
//  Garage_is_complete, Near_full       status, combinational from registered state
//  Occupancy, Free_slots               cars inside, slots not taken or reserved
module garage_gate_controller
  import garage_pkg::*;
#(
  parameter int unsigned CAPACITY     = 10,
  parameter int unsigned OPEN_TIMEOUT = 16,
  parameter int unsigned CLOSE_CYCLES = 4,
  parameter int unsigned NEAR_FULL    = 2,
  localparam int unsigned CW          = $clog2(CAPACITY + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Car_entry_request,
  input  logic          Car_exit_request,
  input  logic          Entry_passed,
  input  logic          Exit_passed,
  output logic          Open_entry_door,
  output logic          Open_exit_door,
  output logic          Garage_is_complete,
  output logic          Near_full,
  output logic [CW-1:0] Occupancy,
  output logic [CW-1:0] Free_slots
);
  logic e_acc, e_to, x_acc, x_to, res;
  logic [CW-1:0] occ_nx;
  garage_gate_fsm #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_CYCLES(CLOSE_CYCLES)) u_entry (
    .clk(Clk), .rst(Reset), .request(Car_entry_request), .permit(!Garage_is_complete),
    .pass(Entry_passed), .door(Open_entry_door), .pass_accepted(e_acc), .timeout(e_to)
  );
  garage_gate_fsm #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_CYCLES(CLOSE_CYCLES)) u_exit (
    .clk(Clk), .rst(Reset), .request(Car_exit_request), .permit(Occupancy != '0),
    .pass(Exit_passed), .door(Open_exit_door), .pass_accepted(x_acc), .timeout(x_to)
  );
  // The entry reservation is taken on the edge the gate opens and released on the edge it
  // leaves OPEN (pass or timeout), so it coincides exactly with the entry gate being OPEN.
  assign res = Open_entry_door;
  always_comb begin
    occ_nx = (e_acc && !x_acc && Occupancy != CW'(CAPACITY)) ? Occupancy + 1'b1 :
             (x_acc && !e_acc && Occupancy != '0) ? Occupancy - 1'b1 : Occupancy;
    Garage_is_complete = 32'(Occupancy) + 32'(res) == CAPACITY;
    Free_slots = CW'(CAPACITY) - Occupancy - CW'(res);
    Near_full = 32'(Free_slots) <= NEAR_FULL;
  end
  always_ff @(posedge Clk) begin
    if (Reset) Occupancy <= '0;
    else begin
      Occupancy <= occ_nx;
      assert (!(e_acc && !x_acc && Occupancy == CW'(CAPACITY))) else $error("occupancy overflow");
      assert (!(x_acc && !e_acc && Occupancy == '0)) else $error("occupancy underflow");
      assert (!(e_acc && e_to) && !(x_acc && x_to)) else $error("pass and timeout together");
    end
  end
endmodule

// File: tb/tb_garage_gate_controller.sv
// tb_garage_gate_controller: directed vectors for a 3-slot garage
module tb_garage_gate_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic entry_req = 1'b0, exit_req = 1'b0, entry_pass = 1'b0, exit_pass = 1'b0;
  logic entry_door, exit_door, complete, near_full;
  logic [1:0] occ, free;
  int vecs = 0;
  int miscompares = 0;

  garage_gate_controller #(.CAPACITY(3), .OPEN_TIMEOUT(8), .CLOSE_CYCLES(2), .NEAR_FULL(1)) dut (
    .Clk(clk), .Reset(rst), .Car_entry_request(entry_req), .Car_exit_request(exit_req),
    .Entry_passed(entry_pass), .Exit_passed(exit_pass), .Open_entry_door(entry_door),
    .Open_exit_door(exit_door), .Garage_is_complete(complete), .Near_full(near_full),
    .Occupancy(occ), .Free_slots(free)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_status(input string tag, input int e_door, input int x_door,
                            input int o, input int f, input int c, input int n);
    chk({tag, " entry_door"}, 32'(entry_door), e_door);
    chk({tag, " exit_door"}, 32'(exit_door), x_door);
    chk({tag, " occupancy"}, 32'(occ), o);
    chk({tag, " free"}, 32'(free), f);
    chk({tag, " complete"}, 32'(complete), c);
    chk({tag, " near_full"}, 32'(near_full), n);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_status("reset", 0, 0, 0, 3, 0, 0);
    // basic entry: request at cycle 0, pass at cycle 3
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    chk_status("entry c1", 1, 0, 0, 2, 0, 0);
    tick();
    tick();
    chk("entry c3 door", 32'(entry_door), 1);
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    chk_status("entry c4", 0, 0, 1, 2, 0, 0);
    entry_req = 1'b1;
    tick();
    chk("closing c5 door", 32'(entry_door), 0);
    tick();
    chk("closing c6 door", 32'(entry_door), 0);
    tick();
    chk_status("reopen c7", 1, 0, 1, 1, 0, 1);
    entry_req = 1'b0;
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b1;
    chk_status("dup pass", 0, 0, 2, 1, 0, 1);
    tick();
    entry_pass = 1'b0;
    chk("dup pass ignored occ", 32'(occ), 2);
    tick();
    // third car fills the garage
    entry_req = 1'b1;
    tick();
    chk_status("third open", 1, 0, 2, 0, 1, 1);
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    chk_status("full", 0, 0, 3, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full held req door", 32'(entry_door), 0);
    end
    // exit from full; held entry request must open after complete drops
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    chk_status("exit open", 0, 1, 3, 0, 1, 1);
    exit_pass = 1'b1;
    tick();
    exit_pass = 1'b0;
    chk_status("after exit", 0, 0, 2, 1, 0, 1);
    tick();
    entry_req = 1'b0;
    chk_status("pending entry opens", 1, 0, 2, 0, 1, 1);
    // timeout: door high for exactly 8 cycles
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("timeout door %0d", i), 32'(entry_door), 1);
      tick();
    end
    chk_status("timed out", 0, 0, 2, 1, 0, 1);
    tick();
    tick();
    // simultaneous passes
    entry_req = 1'b1;
    exit_req = 1'b1;
    tick();
    entry_req = 1'b0;
    exit_req = 1'b0;
    chk_status("both open", 1, 1, 2, 0, 1, 1);
    entry_pass = 1'b1;
    exit_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    exit_pass = 1'b0;
    chk_status("both passed", 0, 0, 2, 1, 0, 1);
    tick();
    tick();
    // mid-operation reset: exit open, entry closing
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    entry_pass = 1'b1;
    exit_req = 1'b1;
    tick();
    entry_pass = 1'b0;
    exit_req = 1'b0;
    chk_status("pre reset", 0, 1, 3, 0, 1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_status("mid reset", 0, 0, 0, 3, 0, 0);
    exit_req = 1'b1;
    tick();
    chk("empty exit door 1", 32'(exit_door), 0);
    tick();
    exit_req = 1'b0;
    chk("empty exit door 2", 32'(exit_door), 0);
    entry_pass = 1'b1;
    exit_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    exit_pass = 1'b0;
    chk("idle passes ignored", 32'(occ), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
